// File: rtl/reg_context_ctrl_if.sv
// Bundles the pipeline write-back path, CALL/RET strobes, register snapshot
// inputs and the status outputs of the call/return context sequencer.
interface reg_context_ctrl_if #(parameter int CW = 7);
  logic        call_flag;
  logic        ret_flag;
  logic [31:0] r_eax;
  logic [31:0] r_ebx;
  logic [31:0] r_ecx;
  logic [31:0] r_edx;
  logic        cpu_wb_flag;
  logic [7:0]  cpu_wb_code;
  logic [31:0] cpu_wb_data;
  logic        REG_write_back_flag;
  logic [7:0]  REG_write_back_code;
  logic [31:0] REG_write_back_data;
  logic        busy;
  logic [CW-1:0] depth_count;
  logic        err_overflow;
  logic        err_underflow;

  modport slave (
    input  call_flag, ret_flag, r_eax, r_ebx, r_ecx, r_edx,
           cpu_wb_flag, cpu_wb_code, cpu_wb_data,
    output REG_write_back_flag, REG_write_back_code, REG_write_back_data,
           busy, depth_count, err_overflow, err_underflow
  );

  modport master (
    output call_flag, ret_flag, r_eax, r_ebx, r_ecx, r_edx,
           cpu_wb_flag, cpu_wb_code, cpu_wb_data,
    input  REG_write_back_flag, REG_write_back_code, REG_write_back_data,
           busy, depth_count, err_overflow, err_underflow
  );
endinterface

// File: rtl/reg_context_ctrl.sv
// Call/return context sequencer: CALL pushes {edx,ecx,ebx,eax} onto a LIFO,
// RET pops the newest entry and replays it as four write-back transactions.
module reg_context_ctrl #(
  parameter int DEPTH = 64,
  parameter int CW    = 7
) (
  input  logic clock,
  input  logic init,
  reg_context_ctrl_if.slave bus
);
  localparam int AW = CW - 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {IDLE, RESTORE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          push, pop;
  logic [AW-1:0] wr_addr, rd_addr;

  logic [127:0]  mem [DEPTH];
  logic [127:0]  entry_q;

  logic          wb_flag;
  logic [7:0]    wb_code;
  logic [31:0]   wb_data;
  logic          busy;

  assign wr_addr = depth_q[AW-1:0];
  assign rd_addr = AW'(depth_q - CW'(1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        // CALL has priority; a simultaneous RET is silently dropped.
        if (bus.call_flag) begin
          if (depth_q < FULL) begin
            push    = 1'b1;
            depth_d = depth_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else if (bus.ret_flag) begin
          if (depth_q != '0) begin
            pop     = 1'b1;
            depth_d = depth_q - CW'(1);
            idx_d   = 2'd0;
            state_d = RESTORE;
          end else begin
            unf_d = 1'b1;
          end
        end
      end
      RESTORE: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge init) begin
    if (!init) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately unreset; the popped entry is held locally so the
  // replayed words stay stable while the register file is being rewritten.
  always_ff @(posedge clock) begin
    if (push) mem[wr_addr] <= {bus.r_edx, bus.r_ecx, bus.r_ebx, bus.r_eax};
    if (pop)  entry_q <= mem[rd_addr];
  end

  always_comb begin
    wb_flag = bus.cpu_wb_flag;
    wb_code = bus.cpu_wb_code;
    wb_data = bus.cpu_wb_data;
    busy    = 1'b0;
    if (state_q == RESTORE) begin
      // Codes 80/A0/C0/E0 are just idx placed in bits [6:5] under a set MSB.
      wb_flag = 1'b1;
      wb_code = {1'b1, idx_q, 5'b0};
      wb_data = entry_q[{idx_q, 5'b0} +: 32];
      busy    = 1'b1;
    end
  end

  assign bus.REG_write_back_flag = wb_flag;
  assign bus.REG_write_back_code = wb_code;
  assign bus.REG_write_back_data = wb_data;
  assign bus.busy                = busy;
  assign bus.depth_count         = depth_q;
  assign bus.err_overflow        = ovf_q;
  assign bus.err_underflow       = unf_q;
endmodule
